// File: rtl/ram_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one synchronous single-port RAM between the Z80 CPU and the
//            video fetcher; video has priority with a bounded CPU wait.
// Revision : 1.0
//==============================================================================
module ram_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int VID_AW   = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              vid_req,
    input  logic [VID_AW-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [7:0]        vid_rdata,
    output logic              vid_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [15:0]       ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int              WCW          = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0]  c_MAX_WAIT   = WCW'(MAX_WAIT);
    localparam logic [15:0]     c_RAM_BASE   = 16'h4000;
    localparam logic [1:0]      c_TAG_NONE   = 2'd0;
    localparam logic [1:0]      c_TAG_VID    = 2'd1;
    localparam logic [1:0]      c_TAG_CPU_RD = 2'd2;
    localparam logic [1:0]      c_TAG_CPU_WR = 2'd3;

    logic           r_cpu_req_d;
    logic           r_cpu_pend;
    logic [WCW-1:0] r_wcnt;
    logic [1:0]     r_tag0;
    logic [1:0]     r_tag1;

    logic           w_cpu_new;
    logic           w_expired;
    logic           w_vid_win;
    logic           w_cpu_win;
    logic           w_pend_next;
    logic [1:0]     w_tag_next;
    logic           w_inflight_next;

    always_comb begin
        w_cpu_new   = cpu_req & ~r_cpu_req_d;
        w_expired   = (r_wcnt >= c_MAX_WAIT);
        // The pending flag used here is the one registered before this edge,
        // so a brand-new CPU request always loses its first edge to video.
        w_vid_win   = vid_req & (~r_cpu_pend | ~w_expired);
        w_cpu_win   = r_cpu_pend & (~vid_req | w_expired);
        w_pend_next = (r_cpu_pend & ~w_cpu_win) | w_cpu_new;
        w_tag_next  = c_TAG_NONE;
        if (w_cpu_win) begin
            w_tag_next = cpu_we ? c_TAG_CPU_WR : c_TAG_CPU_RD;
        end else if (w_vid_win) begin
            w_tag_next = c_TAG_VID;
        end
        // A write is acknowledged one edge after issue, a read two edges after.
        w_inflight_next = (w_tag_next == c_TAG_CPU_RD) | (w_tag_next == c_TAG_CPU_WR)
                        | (r_tag0 == c_TAG_CPU_RD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Treat the request as already high so one held across reset is ignored.
            r_cpu_req_d <= 1'b1;
            r_cpu_pend  <= 1'b0;
            r_wcnt      <= '0;
            r_tag0      <= c_TAG_NONE;
            r_tag1      <= c_TAG_NONE;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            vid_gnt     <= 1'b0;
            vid_valid   <= 1'b0;
            vid_rdata   <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            cpu_wait_n  <= 1'b1;
        end else begin
            r_cpu_req_d <= cpu_req;
            r_cpu_pend  <= w_pend_next;
            if (w_cpu_win) begin
                r_wcnt <= '0;
            end else if (r_cpu_pend && w_vid_win) begin
                r_wcnt <= r_wcnt + WCW'(1);
            end

            r_tag0  <= w_tag_next;
            r_tag1  <= r_tag0;
            ram_en  <= w_cpu_win | w_vid_win;
            ram_we  <= w_cpu_win & cpu_we;
            vid_gnt <= w_vid_win;
            if (w_cpu_win) begin
                ram_addr  <= cpu_addr - c_RAM_BASE;
                ram_wdata <= cpu_wdata;
            end else if (w_vid_win) begin
                ram_addr  <= 16'(vid_addr);
            end

            vid_valid <= (r_tag1 == c_TAG_VID);
            if (r_tag1 == c_TAG_VID) begin
                vid_rdata <= ram_rdata;
            end
            cpu_ack <= (r_tag1 == c_TAG_CPU_RD) | (r_tag0 == c_TAG_CPU_WR);
            if (r_tag1 == c_TAG_CPU_RD) begin
                cpu_rdata <= ram_rdata;
            end
            cpu_wait_n <= ~(w_pend_next | w_inflight_next);
        end
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port arbiter sharing the 48K system RAM between the Z80 CPU and the video fetcher. It replaces the dual-port arrangement, so the RAM can be one synchronous single-port array. Video reads have priority, with a bounded-wait guarantee for the CPU. It also maps CPU addresses 0x4000–0xFFFF onto RAM offsets and stalls the CPU via a wait output.

## Interface
Parameters:
- MAX_WAIT, default 4: number of consecutive sampling edges a pending CPU access may lose to video before the CPU is forced to win.
- VID_AW, default 13: video address width, zero-extended to 16 bits.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low.
- cpu_req  in  1  CPU RAM access request. Level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Stable while cpu_req is high.
- cpu_addr  in  16  CPU address; only 0x4000–0xFFFF is requested.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid in the cycle cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait_n  out  1  0 while a CPU transaction is pending.
- vid_req  in  1  video read request. Level; one read issued per grant.
- vid_addr  in  VID_AW  video RAM offset.
- vid_gnt  out  1  one-cycle pulse: video request sampled and issued.
- vid_rdata  out  8  video read data.
- vid_valid  out  1  one-cycle pulse: vid_rdata valid.
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  16  RAM offset (registered).
- ram_wdata  out  8  RAM write data (registered).
- ram_rdata  in  8  RAM read data, one cycle after the RAM samples ram_en.

## Operation
Pending flag:
- cpu_pend is set at the edge where cpu_req=1 and the previous-cycle cpu_req=0, i.e. a new transaction.
- cpu_pend is cleared at the edge the CPU is granted.
- The requester deasserts cpu_req for at least 1 cycle between transactions.

Arbitration happens at every edge E0, choosing one of:
- Video: when vid_req=1 and (cpu_pend=0 or wcnt<MAX_WAIT). ram_en=1, ram_we=0, ram_addr={zeros, vid_addr}, and vid_gnt pulses.
- CPU: when cpu_pend=1 and (vid_req=0 or wcnt≥MAX_WAIT). ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr−0x4000 (16-bit modulo), ram_wdata=cpu_wdata.
- Idle: otherwise, ram_en=0 and ram_we=0.

Wait counter:
- wcnt increments, saturating at MAX_WAIT, at each edge where cpu_pend=1 and video wins.
- wcnt clears at a CPU grant.

Pipeline tag:
- A 2-entry shift tag records {none, vid, cpu_rd, cpu_wr} per issued access. Response routing uses this tag only.

Responses:
- Video read and CPU read: data registered from ram_rdata into vid_rdata/cpu_rdata, with vid_valid/cpu_ack pulsed for 1 cycle.
- CPU write: cpu_ack pulses 1 cycle after issue; no read-back.

cpu_wait_n:
- cpu_wait_n = ~(cpu_pend | cpu_inflight); it is registered.
- It returns to 1 in the same cycle cpu_ack is high.

Ordering:
- Accesses complete in issue order.
- A CPU write followed by a video read of the same offset returns the new data.

## Timing
- Grant at edge E0. RAM signals are valid in cycle E0→E1, and the RAM samples them at E1.
- Data is captured at E2, so cpu_rdata/vid_rdata with cpu_ack/vid_valid are high in cycle E2→E3. Read latency is 2 edges from grant.
- Write: cpu_ack is high in cycle E1→E2.
- Throughput: one access per cycle. Back-to-back video grants are allowed while CPU is idle or wcnt<MAX_WAIT.
- Worst-case CPU latency, from the edge setting cpu_pend to cpu_ack: MAX_WAIT+1 grant edges plus 2 for reads, 1 for writes.
- Simultaneous new cpu_req and vid_req at the same edge: cpu_pend is only set at that edge, so video wins that edge.
- Reset (reset_n=0 sampled at an edge):
  - all outputs 0 except cpu_wait_n=1;
  - cpu_pend, wcnt and the pipeline tags are cleared, and in-flight accesses are discarded;
  - no vid_valid/cpu_ack pulses follow reset.
- A cpu_req held high across reset release does not start a transaction until it has been low for 1 cycle.

## Test plan
- Reset, then idle: all outputs 0, cpu_wait_n=1, ram_en=0 for 10 cycles.
- CPU write 0x5A to 0x4000, then CPU read 0x4000, no video:
  - write: ram_addr=0x0000, ram_we=1, cpu_ack 1 cycle after the grant;
  - read: cpu_rdata=0x5A with cpu_ack 2 cycles after the grant;
  - cpu_wait_n is low only in between.
- vid_req continuously high with addresses 0x0000..0x001F, RAM preloaded: one vid_valid per cycle, returning data in order with 2-cycle latency.
- vid_req continuously high plus a CPU read of 0xFFFF with MAX_WAIT=4: exactly 4 video grants, then a CPU grant with ram_addr=0xBFFF, then video resumes. wcnt=0 after the CPU grant.
- CPU write 0x33 to 0x4010, followed next cycle by a video read of offset 0x0010: vid_rdata=0x33.
- reset_n pulsed low one cycle after a video grant: no vid_valid, all outputs at their reset values, and normal operation on the next request.
